// File: rtl/mbx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mbx_pkg                                                                    |
// | Shared defaults, error bit indices and width helpers for the mailbox.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mbx_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int NUM_CH_DEF = 4;

  // Bit positions inside each channel's {ovf,unf} error pair
  localparam int ERR_UNF = 0;
  localparam int ERR_OVF = 1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mbx_fifo                                                                   |
// | Single-clock FIFO with registered read data, flush and error pulses.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mbx_fifo
  import mbx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_pop_ok,
  output logic              o_ovf,
  output logic              o_unf,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  localparam int AW = PTR_W - 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;

  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  // Flush overrides both sides; a pop frees the slot a full-FIFO push needs
  assign w_pop  = i_pop & ~w_empty & ~i_flush;
  assign w_push = i_push & (~w_full | w_pop) & ~i_flush;

  assign o_ovf    = i_push & w_full & ~w_pop & ~i_flush;
  assign o_unf    = i_pop & w_empty & ~i_flush;
  assign o_pop_ok = w_pop;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_count  = CNT_W'(r_wptr - r_rptr);
  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_pop;
      if (i_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop) begin
          r_rptr  <= r_rptr + PTR_W'(1);
          r_rdata <= r_mem[r_rptr[AW-1:0]];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mbx_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mbx_bridge                                                                 |
// | Multi-channel bidirectional HPS<->NIOS mailbox with sticky errors.         |
// | Optional interrupts enabled by defining MBX_IRQ_EN.                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mbx_bridge
  import mbx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int CH_W  = ch_w(NUM_CH)
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
`ifdef MBX_IRQ_EN
  input  logic [NUM_CH-1:0]   arm_irq_mask,
  input  logic [NUM_CH-1:0]   nios_irq_mask,
  output logic                arm_irq,
  output logic                nios_irq,
`endif
  input  logic [CH_W-1:0]     arm_sel,
  input  logic                arm_wr,
  input  logic [DATA_W-1:0]   arm_wdata,
  input  logic                arm_rd,
  output logic [DATA_W-1:0]   arm_rdata,
  output logic                arm_rvalid,
  input  logic                arm_clr,
  output logic [NUM_CH-1:0]   arm_not_empty,
  output logic [NUM_CH-1:0]   arm_full,
  output logic [2*NUM_CH-1:0] arm_err,
  input  logic [CH_W-1:0]     nios_sel,
  input  logic                nios_wr,
  input  logic [DATA_W-1:0]   nios_wdata,
  input  logic                nios_rd,
  output logic [DATA_W-1:0]   nios_rdata,
  output logic                nios_rvalid,
  input  logic                nios_clr,
  output logic [NUM_CH-1:0]   nios_not_empty,
  output logic [NUM_CH-1:0]   nios_full,
  output logic [2*NUM_CH-1:0] nios_err
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [NUM_CH-1:0] w_a2n_pop_ok;
  logic [NUM_CH-1:0] w_n2a_pop_ok;
  logic [NUM_CH-1:0] w_a2n_rvalid;
  logic [NUM_CH-1:0] w_n2a_rvalid;
  logic [DATA_W-1:0] w_a2n_rdata [NUM_CH];
  logic [DATA_W-1:0] w_n2a_rdata [NUM_CH];
  logic [CH_W-1:0]   r_arm_rsel;
  logic [CH_W-1:0]   r_nios_rsel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             w_arm_hit;
    logic             w_nios_hit;
    logic             w_a2n_ovf;
    logic             w_a2n_unf;
    logic             w_n2a_ovf;
    logic             w_n2a_unf;
    logic             w_a2n_empty;
    logic             w_n2a_empty;
    logic [CNT_W-1:0] w_a2n_cnt_unused;
    logic [CNT_W-1:0] w_n2a_cnt_unused;
    logic [1:0]       r_arm_err;
    logic [1:0]       r_nios_err;

    // Out-of-range selects match no channel and are silently ignored
    assign w_arm_hit  = (arm_sel == CH_W'(i));
    assign w_nios_hit = (nios_sel == CH_W'(i));

    mbx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_a2n (
      .clk      (clk_clk),
      .rst_n    (reset_reset_n),
      .i_push   (arm_wr & w_arm_hit),
      .i_pop    (nios_rd & w_nios_hit),
      .i_flush  (nios_clr & w_nios_hit),
      .i_wdata  (arm_wdata),
      .o_rdata  (w_a2n_rdata[i]),
      .o_rvalid (w_a2n_rvalid[i]),
      .o_pop_ok (w_a2n_pop_ok[i]),
      .o_ovf    (w_a2n_ovf),
      .o_unf    (w_a2n_unf),
      .o_full   (arm_full[i]),
      .o_empty  (w_a2n_empty),
      .o_count  (w_a2n_cnt_unused)
    );

    mbx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_n2a (
      .clk      (clk_clk),
      .rst_n    (reset_reset_n),
      .i_push   (nios_wr & w_nios_hit),
      .i_pop    (arm_rd & w_arm_hit),
      .i_flush  (arm_clr & w_arm_hit),
      .i_wdata  (nios_wdata),
      .o_rdata  (w_n2a_rdata[i]),
      .o_rvalid (w_n2a_rvalid[i]),
      .o_pop_ok (w_n2a_pop_ok[i]),
      .o_ovf    (w_n2a_ovf),
      .o_unf    (w_n2a_unf),
      .o_full   (nios_full[i]),
      .o_empty  (w_n2a_empty),
      .o_count  (w_n2a_cnt_unused)
    );

    assign arm_not_empty[i]  = ~w_n2a_empty;
    assign nios_not_empty[i] = ~w_a2n_empty;

    // Each side owns ovf of the FIFO it writes and unf of the FIFO it reads
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        r_arm_err <= '0;
      end else if (arm_clr && w_arm_hit) begin
        r_arm_err <= '0;
      end else begin
        if (w_a2n_ovf) r_arm_err[ERR_OVF] <= 1'b1;
        if (w_n2a_unf) r_arm_err[ERR_UNF] <= 1'b1;
      end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        r_nios_err <= '0;
      end else if (nios_clr && w_nios_hit) begin
        r_nios_err <= '0;
      end else begin
        if (w_n2a_ovf) r_nios_err[ERR_OVF] <= 1'b1;
        if (w_a2n_unf) r_nios_err[ERR_UNF] <= 1'b1;
      end
    end

    assign arm_err[2*i +: 2]  = r_arm_err;
    assign nios_err[2*i +: 2] = r_nios_err;
  end

  // Remember the channel of the last successful pop so rdata holds across sel changes
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_arm_rsel  <= '0;
      r_nios_rsel <= '0;
    end else begin
      if (|w_n2a_pop_ok) r_arm_rsel <= arm_sel;
      if (|w_a2n_pop_ok) r_nios_rsel <= nios_sel;
    end
  end

  assign arm_rdata   = w_n2a_rdata[r_arm_rsel];
  assign arm_rvalid  = |w_n2a_rvalid;
  assign nios_rdata  = w_a2n_rdata[r_nios_rsel];
  assign nios_rvalid = |w_a2n_rvalid;

`ifdef MBX_IRQ_EN
  logic r_arm_irq;
  logic r_nios_irq;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_arm_irq  <= 1'b0;
      r_nios_irq <= 1'b0;
    end else begin
      r_arm_irq  <= |(arm_not_empty & ~arm_irq_mask);
      r_nios_irq <= |(nios_not_empty & ~nios_irq_mask);
    end
  end

  assign arm_irq  = r_arm_irq;
  assign nios_irq = r_nios_irq;
`endif

endmodule
`default_nettype wire
